// File: rtl/spi_slave_reg_ctrl.sv
// Register-access controller behind an 8-bit SPI slave.
// Each frame is one command word followed by data words. The command word
// carries R/W (bit 7) and a 7-bit start address; data words auto-increment
// the address. The slave has no chip-select, so a frame ends when the link
// has been quiet (no received word, slave not busy) for p_timeout cycles.
module spi_slave_reg_ctrl #(
    parameter int          p_num_regs = 16,
    parameter int          p_timeout  = 64,
    parameter logic [7:0]  p_idle_tx  = 8'hA5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_valid,
    input  logic                      i_busy,
    output logic [7:0]                o_tx_data,
    output logic [8*p_num_regs-1:0]   o_regs,
    output logic                      o_wr_strobe,
    output logic [6:0]                o_wr_addr,
    output logic                      o_addr_err,
    output logic                      o_frame_active
);

    // Wide enough to hold p_timeout-1.
    localparam int TW = (p_timeout > 2) ? $clog2(p_timeout) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(p_timeout - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [6:0]      ptr_reg;
    logic [TW-1:0]   tmo_reg;
    logic [7:0]      tx_reg;
    logic            wr_strobe_reg;
    logic [6:0]      wr_addr_reg;
    logic            addr_err_reg;
    logic            active_reg;
    logic [7:0]      regs_reg [p_num_regs];

    logic [6:0]      rd_addr;
    logic [7:0]      rd_data;
    logic            rd_in_range;
    logic            ptr_in_range;
    logic            wr_en;

    // Address whose contents become the next tx word: the command's address
    // when opening a read frame, otherwise the pointer after increment.
    always_comb begin
        rd_addr = (state_reg == IDLE) ? i_rx_data[6:0] : (ptr_reg + 7'd1);
    end

    // Register read mux; out-of-range addresses read as zero.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < p_num_regs; i++) begin
            if (rd_addr == 7'(i)) begin
                rd_data = regs_reg[i];
            end
        end
    end

    // Range checks are done after the 7-bit wrap, so compare in 8 bits.
    always_comb begin
        rd_in_range  = ({1'b0, rd_addr} < 8'(p_num_regs));
        ptr_in_range = ({1'b0, ptr_reg} < 8'(p_num_regs));
        wr_en        = i_rx_valid && (state_reg == WRITE) && ptr_in_range;
    end

    // One flop group per register, loaded when a data word targets it.
    generate
        for (genvar gi = 0; gi < p_num_regs; gi++) begin : g_regs
            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_reg[gi] <= 8'h00;
                end else if (wr_en && (ptr_reg == 7'(gi))) begin
                    regs_reg[gi] <= i_rx_data;
                end
            end
            assign o_regs[8*gi +: 8] = regs_reg[gi];
        end
    endgenerate

    // Frame FSM: command decode, pointer advance, tx word, strobes, timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= 7'd0;
            tmo_reg       <= '0;
            tx_reg        <= p_idle_tx;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 7'd0;
            addr_err_reg  <= 1'b0;
            active_reg    <= 1'b0;
        end else begin
            wr_strobe_reg <= 1'b0;
            addr_err_reg  <= 1'b0;
            if (i_rx_valid) begin
                // A received word always wins over a simultaneous expiry.
                tmo_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        ptr_reg    <= i_rx_data[6:0];
                        active_reg <= 1'b1;
                        if (i_rx_data[7]) begin
                            state_reg    <= READ;
                            tx_reg       <= rd_data;
                            addr_err_reg <= !rd_in_range;
                        end else begin
                            state_reg <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (ptr_in_range) begin
                            wr_strobe_reg <= 1'b1;
                            wr_addr_reg   <= ptr_reg;
                        end else begin
                            addr_err_reg <= 1'b1;
                        end
                        ptr_reg <= ptr_reg + 7'd1;
                    end
                    READ: begin
                        // The received word is a dummy; it only clocks the read.
                        ptr_reg      <= ptr_reg + 7'd1;
                        tx_reg       <= rd_data;
                        addr_err_reg <= !rd_in_range;
                    end
                    default: begin
                        state_reg  <= IDLE;
                        active_reg <= 1'b0;
                    end
                endcase
            end else if (i_busy) begin
                tmo_reg <= '0;
            end else if (state_reg != IDLE) begin
                if (tmo_reg == TMO_LAST) begin
                    state_reg  <= IDLE;
                    active_reg <= 1'b0;
                    tx_reg     <= p_idle_tx;
                    tmo_reg    <= '0;
                end else begin
                    tmo_reg <= tmo_reg + 1'b1;
                end
            end
        end
    end

    assign o_tx_data      = tx_reg;
    assign o_wr_strobe    = wr_strobe_reg;
    assign o_wr_addr      = wr_addr_reg;
    assign o_addr_err     = addr_err_reg;
    assign o_frame_active = active_reg;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Self-checking bench for spi_slave_reg_ctrl: directed scenarios plus a
// randomized frame stream, all compared against a transaction-level model.
module tb_spi_slave_reg_ctrl;

    localparam int         N       = 16;
    localparam int         TO      = 64;
    localparam logic [7:0] IDLE_TX = 8'hA5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             busy = 1'b0;
    logic [7:0]       o_tx_data;
    logic [8*N-1:0]   o_regs;
    logic             o_wr_strobe;
    logic [6:0]       o_wr_addr;
    logic             o_addr_err;
    logic             o_frame_active;

    int checks   = 0;
    int failures = 0;

    spi_slave_reg_ctrl #(
        .p_num_regs (N),
        .p_timeout  (TO),
        .p_idle_tx  (IDLE_TX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .i_busy         (busy),
        .o_tx_data      (o_tx_data),
        .o_regs         (o_regs),
        .o_wr_strobe    (o_wr_strobe),
        .o_wr_addr      (o_wr_addr),
        .o_addr_err     (o_addr_err),
        .o_frame_active (o_frame_active)
    );

    always #5 clk = ~clk;

    // ---------------- transaction-level reference model ----------------
    logic [7:0] m_regs [N];
    int         m_ptr;
    bit         m_open;
    bit         m_read;
    int         m_quiet;
    logic [7:0] m_tx;
    bit         e_strobe;
    int         e_waddr;
    bit         e_err;

    function automatic logic [7:0] m_fetch(int a);
        return (a < N) ? m_regs[a] : 8'h00;
    endfunction

    function automatic logic [8*N-1:0] m_flat();
        logic [8*N-1:0] f;
        for (int i = 0; i < N; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
        m_ptr = 0; m_open = 0; m_read = 0; m_quiet = 0;
        m_tx = IDLE_TX; e_strobe = 0; e_waddr = 0; e_err = 0;
    endtask

    task automatic model_word(input logic [7:0] w);
        e_strobe = 0; e_err = 0; m_quiet = 0;
        if (!m_open) begin
            m_open = 1;
            m_ptr  = int'(w[6:0]);
            m_read = w[7];
            if (m_read) begin
                m_tx  = m_fetch(m_ptr);
                e_err = (m_ptr >= N);
            end
        end else if (!m_read) begin
            if (m_ptr < N) begin
                m_regs[m_ptr] = w;
                e_strobe = 1;
                e_waddr  = m_ptr;
            end else begin
                e_err = 1;
            end
            m_ptr = (m_ptr + 1) % 128;
        end else begin
            m_ptr = (m_ptr + 1) % 128;
            m_tx  = m_fetch(m_ptr);
            e_err = (m_ptr >= N);
        end
    endtask

    // A frame closes after TO consecutive quiet cycles.
    task automatic model_quiet(input bit b);
        e_strobe = 0; e_err = 0;
        if (b) m_quiet = 0;
        else if (m_open) begin
            m_quiet++;
            if (m_quiet == TO) begin
                m_open = 0; m_tx = IDLE_TX; m_quiet = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // leave time so outputs can be sampled 1 unit after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit b);
        @(negedge clk);
        rx_valid = v; rx_data = d; busy = b;
        @(posedge clk);
        if (rst) model_reset();
        else if (v) model_word(d);
        else model_quiet(b);
        #1;
    endtask

    task automatic word(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic gap();
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic close_frame();
        for (int i = 0; i < TO + 1; i++) gap();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        gap(); gap();
        rst = 1'b0;
        checks++; if (o_tx_data !== IDLE_TX) begin failures++; $display("FAIL reset_tx got=%h exp=%h", o_tx_data, IDLE_TX); end
        checks++; if (o_regs !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", o_regs); end
        checks++; if (o_frame_active !== 1'b0 || o_wr_strobe !== 1'b0 || o_addr_err !== 1'b0 || o_wr_addr !== 7'd0) begin
            failures++; $display("FAIL reset_ctrl got act=%b stb=%b err=%b wa=%0d exp 0/0/0/0", o_frame_active, o_wr_strobe, o_addr_err, o_wr_addr);
        end
    endtask

    task automatic test_write_burst();
        logic [7:0] data [3];
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
        word(8'h03);
        checks++; if (o_frame_active !== 1'b1 || o_wr_strobe !== 1'b0) begin failures++; $display("FAIL wr_cmd got act=%b stb=%b exp act=1 stb=0", o_frame_active, o_wr_strobe); end
        gap();
        for (int i = 0; i < 3; i++) begin
            word(data[i]);
            checks++; if (o_wr_strobe !== 1'b1 || o_wr_addr !== 7'(3 + i)) begin failures++; $display("FAIL wr_strobe[%0d] got stb=%b wa=%0d exp stb=1 wa=%0d", i, o_wr_strobe, o_wr_addr, 3 + i); end
            checks++; if (o_regs[8*(3+i) +: 8] !== data[i]) begin failures++; $display("FAIL wr_reg%0d got=%h exp=%h", 3 + i, o_regs[8*(3+i) +: 8], data[i]); end
            gap();
            checks++; if (o_wr_strobe !== 1'b0) begin failures++; $display("FAIL wr_strobe_len[%0d] got=%b exp=0", i, o_wr_strobe); end
        end
        checks++; if (o_regs !== 128'h0000_0000_0000_0000_0000_3322_1100_0000) begin failures++; $display("FAIL wr_bank got=%h exp=%h", o_regs, 128'h0000_0000_0000_0000_0000_3322_1100_0000); end
        close_frame();
    endtask

    task automatic test_read_burst();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h5A; exp_seq[1] = 8'h6B; exp_seq[2] = 8'h7C;
        word(8'h00); gap();
        for (int i = 0; i < 3; i++) begin word(exp_seq[i]); gap(); end
        close_frame();
        word(8'h80);
        for (int i = 0; i < 3; i++) begin
            checks++; if (o_tx_data !== exp_seq[i]) begin failures++; $display("FAIL rd_tx[%0d] got=%h exp=%h", i, o_tx_data, exp_seq[i]); end
            checks++; if (o_wr_strobe !== 1'b0 || o_addr_err !== 1'b0) begin failures++; $display("FAIL rd_flags[%0d] got stb=%b err=%b exp 0/0", i, o_wr_strobe, o_addr_err); end
            gap();
            if (i < 2) word(8'hFF);
        end
        checks++; if (o_regs[7:0] !== 8'h5A) begin failures++; $display("FAIL rd_no_write got=%h exp=5a", o_regs[7:0]); end
        close_frame();
    endtask

    task automatic test_timeout();
        word(8'h81);
        checks++; if (o_tx_data !== 8'h6B) begin failures++; $display("FAIL to_cmd_tx got=%h exp=6b", o_tx_data); end
        for (int i = 0; i < TO - 1; i++) gap();
        checks++; if (o_frame_active !== 1'b1) begin failures++; $display("FAIL to_early got=%b exp=1", o_frame_active); end
        gap();
        checks++; if (o_frame_active !== 1'b0 || o_tx_data !== IDLE_TX) begin failures++; $display("FAIL to_expire got act=%b tx=%h exp act=0 tx=%h", o_frame_active, o_tx_data, IDLE_TX); end
        word(8'h02);
        checks++; if (o_frame_active !== 1'b1 || o_tx_data !== IDLE_TX || o_wr_strobe !== 1'b0) begin failures++; $display("FAIL to_newcmd got act=%b tx=%h stb=%b exp 1/%h/0", o_frame_active, o_tx_data, o_wr_strobe, IDLE_TX); end
        gap();
        word(8'h44);
        checks++; if (o_wr_strobe !== 1'b1 || o_wr_addr !== 7'd2 || o_regs[23:16] !== 8'h44) begin failures++; $display("FAIL to_write got stb=%b wa=%0d r2=%h exp 1/2/44", o_wr_strobe, o_wr_addr, o_regs[23:16]); end
        close_frame();
    endtask

    task automatic test_range_wrap();
        word(8'h0F); gap();
        checks++; if (o_addr_err !== 1'b0) begin failures++; $display("FAIL rw_cmd_err got=%b exp=0", o_addr_err); end
        word(8'hEE);
        checks++; if (o_wr_strobe !== 1'b1 || o_wr_addr !== 7'd15 || o_regs[127:120] !== 8'hEE) begin failures++; $display("FAIL rw_reg15 got stb=%b wa=%0d r15=%h exp 1/15/ee", o_wr_strobe, o_wr_addr, o_regs[127:120]); end
        gap();
        word(8'hFF);
        checks++; if (o_addr_err !== 1'b1 || o_wr_strobe !== 1'b0) begin failures++; $display("FAIL rw_oob got err=%b stb=%b exp err=1 stb=0", o_addr_err, o_wr_strobe); end
        gap();
        checks++; if (o_addr_err !== 1'b0) begin failures++; $display("FAIL rw_err_len got=%b exp=0", o_addr_err); end
        close_frame();
        word(8'h7F);
        checks++; if (o_addr_err !== 1'b0) begin failures++; $display("FAIL rw_cmd7f_err got=%b exp=0", o_addr_err); end
        gap();
        word(8'h01);
        checks++; if (o_addr_err !== 1'b1 || o_wr_strobe !== 1'b0) begin failures++; $display("FAIL rw_127 got err=%b stb=%b exp 1/0", o_addr_err, o_wr_strobe); end
        gap();
        word(8'h02);
        checks++; if (o_wr_strobe !== 1'b1 || o_wr_addr !== 7'd0 || o_regs[7:0] !== 8'h02 || o_addr_err !== 1'b0) begin failures++; $display("FAIL rw_wrap got stb=%b wa=%0d r0=%h err=%b exp 1/0/02/0", o_wr_strobe, o_wr_addr, o_regs[7:0], o_addr_err); end
        close_frame();
    endtask

    task automatic test_simultaneous();
        word(8'h05);
        for (int i = 0; i < TO - 1; i++) gap();
        word(8'h77);
        checks++; if (o_frame_active !== 1'b1 || o_wr_strobe !== 1'b1 || o_wr_addr !== 7'd5 || o_regs[47:40] !== 8'h77) begin
            failures++; $display("FAIL sim_edge got act=%b stb=%b wa=%0d r5=%h exp 1/1/5/77", o_frame_active, o_wr_strobe, o_wr_addr, o_regs[47:40]);
        end
        for (int i = 0; i < TO - 1; i++) gap();
        checks++; if (o_frame_active !== 1'b1) begin failures++; $display("FAIL sim_restart got=%b exp=1", o_frame_active); end
        gap();
        checks++; if (o_frame_active !== 1'b0) begin failures++; $display("FAIL sim_close got=%b exp=0", o_frame_active); end
    endtask

    task automatic test_reset_mid();
        word(8'h08); gap();
        word(8'h99); gap();
        rst = 1'b1;
        gap();
        rst = 1'b0;
        checks++; if (o_regs !== '0 || o_frame_active !== 1'b0 || o_tx_data !== IDLE_TX) begin
            failures++; $display("FAIL rstmid got regs=%h act=%b tx=%h exp 0/0/%h", o_regs, o_frame_active, o_tx_data, IDLE_TX);
        end
        word(8'h0A); gap();
        checks++; if (o_wr_strobe !== 1'b0 || o_frame_active !== 1'b1) begin failures++; $display("FAIL rstmid_cmd got stb=%b act=%b exp 0/1", o_wr_strobe, o_frame_active); end
        word(8'h12);
        checks++; if (o_wr_strobe !== 1'b1 || o_wr_addr !== 7'd10 || o_regs[87:80] !== 8'h12) begin failures++; $display("FAIL rstmid_wr got stb=%b wa=%0d r10=%h exp 1/10/12", o_wr_strobe, o_wr_addr, o_regs[87:80]); end
        close_frame();
    endtask

    typedef struct packed { bit v; logic [7:0] d; bit b; } op_t;

    task automatic test_random();
        op_t ops [$];
        op_t op;
        int  addr;
        for (int t = 0; t < 40; t++) begin
            ops.delete();
            case ($urandom_range(0, 3))
                0:       addr = $urandom_range(0, 127);
                1:       addr = $urandom_range(120, 127);
                default: addr = $urandom_range(0, N + 1);
            endcase
            op.v = 1; op.b = 0; op.d = {1'($urandom_range(0, 1)), 7'(addr)};
            ops.push_back(op);
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    op.v = 0; op.d = 8'h00; op.b = 1'($urandom_range(0, 1));
                    ops.push_back(op);
                end
                op.v = 1; op.b = 0; op.d = 8'($urandom);
                ops.push_back(op);
            end
            for (int g = 0; g < TO + 1; g++) begin
                op.v = 0; op.d = 8'h00; op.b = 0;
                ops.push_back(op);
            end
            foreach (ops[j]) begin
                step(ops[j].v, ops[j].d, ops[j].b);
                checks++; if (o_tx_data !== m_tx) begin failures++; $display("FAIL rand_tx t=%0d j=%0d got=%h exp=%h", t, j, o_tx_data, m_tx); end
                checks++; if (o_regs !== m_flat()) begin failures++; $display("FAIL rand_regs t=%0d j=%0d got=%h exp=%h", t, j, o_regs, m_flat()); end
                checks++; if (o_wr_strobe !== e_strobe || o_wr_addr !== 7'(e_waddr)) begin failures++; $display("FAIL rand_wr t=%0d j=%0d got stb=%b wa=%0d exp stb=%b wa=%0d", t, j, o_wr_strobe, o_wr_addr, e_strobe, e_waddr); end
                checks++; if (o_addr_err !== e_err) begin failures++; $display("FAIL rand_err t=%0d j=%0d got=%b exp=%b", t, j, o_addr_err, e_err); end
                checks++; if (o_frame_active !== m_open) begin failures++; $display("FAIL rand_active t=%0d j=%0d got=%b exp=%b", t, j, o_frame_active, m_open); end
            end
            $display("frame t=%0d cmd=%h ops=%0d", t, ops[0].d, ops.size());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_timeout();
        test_range_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
